fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-stage controller that owns the architectural fetch PC and sequences requests to the instruction cache. It arbitrates between redirect sources: EX-resolved branches, ROB recovery targets and the branch predictor. It tracks the single outstanding I-cache request and discards responses made stale by a redirect. It presents one instruction at a time to decode and holds it under `rob_stall`.

## Interface
- `XLEN`, default 32: PC and instruction width.
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `certain_branch_req` / `certain_branch_pc`  in  1 / XLEN  taken branch resolved in EX; highest priority.
- `rob_target_req` / `rob_target_pc`  in  1 / XLEN  ROB recovery redirect; second priority.
- `branch_pred_req` / `branch_pred_pc`  in  1 / XLEN  predicted-taken target for the instruction being returned this cycle.
- `rob_stall`  in  1  downstream cannot accept the presented instruction.
- `Icache2proc_data`  in  64  aligned 8-byte block.
- `Icache2proc_data_valid`  in  1  response for the oldest outstanding request.
- `proc2Icache_req`  out  1  one-cycle request strobe.
- `proc2Icache_addr`  out  XLEN  `{pc[XLEN-1:3],3'b000}`.
- `if_valid`  out  1  instruction presented (registered).
- `if_inst`, `if_pc`, `if_npc`  out  32 / XLEN / XLEN  instruction, its PC, its predicted next PC (all registered).

## Operation
- `redirect = certain_branch_req | rob_target_req`.
- Target selection: `certain_branch_pc` if `certain_branch_req`, else `rob_target_pc`. Bits [1:0] are forced to 0.
- At most one I-cache request is outstanding. Responses are in order.
- FSM states:
  - **REQ**:
    - `proc2Icache_req`=1.
    - No redirect: go to WAIT.
    - Redirect: pc<=target, go to DROP (the request is already issued).
    - Any data_valid seen in REQ is ignored.
  - **WAIT**:
    - Redirect with !valid: pc<=target, go to DROP.
    - Redirect with valid: discard the response, pc<=target, go to REQ.
    - Valid, no redirect:
      - `if_inst` <= `pc[2]` ? data[63:32] : data[31:0].
      - `if_pc` <= pc.
      - npc = `branch_pred_req` ? `branch_pred_pc` : pc+4.
      - `if_npc` <= npc, pc <= npc.
      - Go to OUT.
  - **DROP**:
    - Redirect: pc<=target; stay in DROP until valid.
    - On valid: discard the response, go to REQ.
  - **OUT**:
    - `if_valid`=1.
    - Redirect: squash (instruction not consumed), pc<=target, no request, go to REQ.
    - Else `rob_stall`: hold all outputs, no request, stay.
    - Else: instruction consumed; `proc2Icache_req`=1 for the new pc; go to WAIT.
- `if_valid` is 1 exactly in OUT. `if_inst`/`if_pc`/`if_npc` change only on the WAIT→OUT capture.
- pc+4 wraps modulo 2^XLEN.
- Simultaneous `certain_branch_req` and `rob_target_req`: certain branch wins.
- `branch_pred_req` is ignored outside an accepted response and when a redirect is present.

## Timing
- Reset:
  - state=REQ, pc=RESET_PC.
  - `if_valid`=0; `if_inst`/`if_pc`/`if_npc`=0.
  - `proc2Icache_req`=1 with `proc2Icache_addr`=aligned RESET_PC in the first cycle after reset deasserts.
- Reset mid-operation abandons any outstanding request. The I-cache is reset in the same cycle, so no response is pending.
- Request issued in cycle N, response at earliest N+1. `if_valid` rises at N+2.
- Steady state with 1-cycle hits and no stall: one instruction every 2 cycles. The next request issues in the same cycle the current instruction is consumed.
- A redirect takes effect on the edge of the cycle it is asserted. `if_valid` is 0 in the next cycle.
- After a DROP, the first request for the target issues the cycle after the stale response.
- `proc2Icache_addr` always reflects the current pc register. It is stable while `proc2Icache_req`=1.

## Configuration
- `FETCH_PRED_EN` defined:
  - The predictor path is active as described above.
- Undefined:
  - `branch_pred_req`/`branch_pred_pc` are ignored.
  - npc is always pc+4; `if_npc`=`if_pc`+4.
  - Predictor-input ports remain present, unused.

## Test plan
- Reset with RESET_PC=0, 1-cycle hits, no stall, data for 0x0 = {0x00000013, 0x00100093}:
  - `if_inst`=0x00000013 at pc 0 with `if_npc`=4.
  - Then 0x00100093 at pc 4; next request address is 0x8.
  - `if_valid` on every other cycle.
- `rob_stall`=1 for 3 cycles while in OUT:
  - `if_valid`/`if_inst`/`if_pc` held constant.
  - `proc2Icache_req`=0 throughout.
  - Request for pc+4 on the cycle `rob_stall` falls.
- Response delayed 4 cycles; `certain_branch_req`=1 with pc 0x100 asserted in cycle 2 of the wait:
  - Stale response discarded; `if_valid` stays 0.
  - Next request address is 0x100 the cycle after the stale valid.
- `certain_branch_req` (0x200) and `rob_target_req` (0x300) asserted in the same cycle: next fetch address is 0x200.
- With `FETCH_PRED_EN`, `branch_pred_req`=1 and `branch_pred_pc`=0x40 accompanying the response for pc 0x10:
  - `if_npc`=0x40; next request address is 0x40.
  - Without the macro: `if_npc`=0x14.
- RESET_PC=0xFFFF_FFFC: after one instruction, `if_npc`=0x0000_0000 and the next request address is 0x0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the fetch PC, issues one I-cache request at a
// time, drops stale responses after redirects. Optional FETCH_PRED_EN macro enables the predictor path.
module fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            certain_branch_req,
  input  logic [XLEN-1:0] certain_branch_pc,
  input  logic            rob_target_req,
  input  logic [XLEN-1:0] rob_target_pc,
  input  logic            branch_pred_req,
  input  logic [XLEN-1:0] branch_pred_pc,
  input  logic            rob_stall,
  input  logic [63:0]     Icache2proc_data,
  input  logic            Icache2proc_data_valid,
  output logic            proc2Icache_req,
  output logic [XLEN-1:0] proc2Icache_addr,
  output logic            if_valid,
  output logic [31:0]     if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_npc
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_OUT} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            redirect;
  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] npc;
  logic [31:0]     inst_sel;

  assign redirect   = certain_branch_req | rob_target_req;
  assign target_raw = certain_branch_req ? certain_branch_pc : rob_target_pc;
  assign target     = {target_raw[XLEN-1:2], 2'b00};
  assign pc_inc     = pc + XLEN'(4);
  assign inst_sel   = pc[2] ? Icache2proc_data[63:32] : Icache2proc_data[31:0];

`ifdef FETCH_PRED_EN
  assign npc = branch_pred_req ? branch_pred_pc : pc_inc;
`else
  logic unused_pred;
  assign unused_pred = branch_pred_req ^ (^branch_pred_pc);
  assign npc         = pc_inc;
`endif

  // OUT issues the next request in the same cycle the instruction is consumed.
  assign proc2Icache_req  = !reset && ((state == S_REQ) ||
                            (state == S_OUT && !redirect && !rob_stall));
  assign proc2Icache_addr = {pc[XLEN-1:3], 3'b000};

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_inst  <= '0;
      if_pc    <= '0;
      if_npc   <= '0;
    end else begin
      case (state)
        S_REQ: begin
          // Request already issued this cycle; a redirect must drop its response.
          if (redirect) begin
            pc    <= target;
            state <= S_DROP;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            pc    <= target;
            state <= Icache2proc_data_valid ? S_REQ : S_DROP;
          end else if (Icache2proc_data_valid) begin
            if_inst  <= inst_sel;
            if_pc    <= pc;
            if_npc   <= npc;
            pc       <= npc;
            if_valid <= 1'b1;
            state    <= S_OUT;
          end
        end
        S_DROP: begin
          if (redirect) pc <= target;
          if (Icache2proc_data_valid) state <= S_REQ;
        end
        S_OUT: begin
          if (redirect) begin
            pc       <= target;
            if_valid <= 1'b0;
            state    <= S_REQ;
          end else if (!rob_stall) begin
            if_valid <= 1'b0;
            state    <= S_WAIT;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; a second instance covers PC wrap.
module tb_fetch_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        cbr, rtr, bpr, rob_stall, dvalid;
  logic [31:0] cbpc, rtpc, bppc;
  logic [63:0] dat;
  logic        req, ivld, req2, ivld2;
  logic [31:0] addr, inst, ipc, inpc, addr2, inst2, ipc2, inpc2;
  int n_pass = 0, n_total = 0;

  localparam logic [63:0] BLK0 = 64'h00100093_00000013;

  always #5 clock = ~clock;

  fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .certain_branch_req(cbr), .certain_branch_pc(cbpc),
    .rob_target_req(rtr), .rob_target_pc(rtpc),
    .branch_pred_req(bpr), .branch_pred_pc(bppc),
    .rob_stall(rob_stall), .Icache2proc_data(dat), .Icache2proc_data_valid(dvalid),
    .proc2Icache_req(req), .proc2Icache_addr(addr),
    .if_valid(ivld), .if_inst(inst), .if_pc(ipc), .if_npc(inpc));

  fetch_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clock(clock), .reset(reset),
    .certain_branch_req(cbr), .certain_branch_pc(cbpc),
    .rob_target_req(rtr), .rob_target_pc(rtpc),
    .branch_pred_req(bpr), .branch_pred_pc(bppc),
    .rob_stall(rob_stall), .Icache2proc_data(dat), .Icache2proc_data_valid(dvalid),
    .proc2Icache_req(req2), .proc2Icache_addr(addr2),
    .if_valid(ivld2), .if_inst(inst2), .if_pc(ipc2), .if_npc(inpc2));

  task automatic clr_in();
    cbr = 0; rtr = 0; bpr = 0; rob_stall = 0; dvalid = 0;
    cbpc = '0; rtpc = '0; bppc = '0; dat = '0;
  endtask

  // Advance to 1ns after the next rising edge; inputs are driven there.
  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Leaves the bench 2ns into the first post-reset cycle (state REQ).
  task automatic do_reset();
    clr_in(); reset = 1;
    tick(); reset = 0; #1;
  endtask

  task automatic test_reset();
    clr_in(); reset = 1;
    tick(); tick();
    if (ivld !== 1'b0) $display("FAIL reset_valid: got %h exp 0", ivld); else n_pass++; n_total++;
    if (inst !== 32'h0) $display("FAIL reset_inst: got %h exp 0", inst); else n_pass++; n_total++;
    if (ipc !== 32'h0) $display("FAIL reset_pc: got %h exp 0", ipc); else n_pass++; n_total++;
    if (inpc !== 32'h0) $display("FAIL reset_npc: got %h exp 0", inpc); else n_pass++; n_total++;
    reset = 0; #1;
    if (req !== 1'b1) $display("FAIL reset_first_req: got %h exp 1", req); else n_pass++; n_total++;
    if (addr !== 32'h0) $display("FAIL reset_first_addr: got %h exp 0", addr); else n_pass++; n_total++;
  endtask

  task automatic test_sequential();
    do_reset();
    tick(); dvalid = 1; dat = BLK0; #1;
    if (req !== 1'b0) $display("FAIL seq_wait_req: got %h exp 0", req); else n_pass++; n_total++;
    if (ivld !== 1'b0) $display("FAIL seq_wait_valid: got %h exp 0", ivld); else n_pass++; n_total++;
    tick(); dvalid = 0; #1;
    if (ivld !== 1'b1) $display("FAIL seq_out0_valid: got %h exp 1", ivld); else n_pass++; n_total++;
    if (inst !== 32'h00000013) $display("FAIL seq_out0_inst: got %h exp 00000013", inst); else n_pass++; n_total++;
    if (ipc !== 32'h0) $display("FAIL seq_out0_pc: got %h exp 0", ipc); else n_pass++; n_total++;
    if (inpc !== 32'h4) $display("FAIL seq_out0_npc: got %h exp 4", inpc); else n_pass++; n_total++;
    if (req !== 1'b1) $display("FAIL seq_out0_req: got %h exp 1", req); else n_pass++; n_total++;
    tick(); dvalid = 1; dat = BLK0; #1;
    if (ivld !== 1'b0) $display("FAIL seq_wait1_valid: got %h exp 0", ivld); else n_pass++; n_total++;
    tick(); dvalid = 0; #1;
    if (ivld !== 1'b1) $display("FAIL seq_out1_valid: got %h exp 1", ivld); else n_pass++; n_total++;
    if (inst !== 32'h00100093) $display("FAIL seq_out1_inst: got %h exp 00100093", inst); else n_pass++; n_total++;
    if (ipc !== 32'h4) $display("FAIL seq_out1_pc: got %h exp 4", ipc); else n_pass++; n_total++;
    if (inpc !== 32'h8) $display("FAIL seq_out1_npc: got %h exp 8", inpc); else n_pass++; n_total++;
    if (req !== 1'b1) $display("FAIL seq_out1_req: got %h exp 1", req); else n_pass++; n_total++;
    if (addr !== 32'h8) $display("FAIL seq_next_addr: got %h exp 8", addr); else n_pass++; n_total++;
  endtask

  task automatic test_stall();
    do_reset();
    tick(); dvalid = 1; dat = BLK0;
    tick(); dvalid = 0; rob_stall = 1; #1;
    for (int i = 0; i < 3; i++) begin
      if (ivld !== 1'b1) $display("FAIL stall_valid[%0d]: got %h exp 1", i, ivld); else n_pass++; n_total++;
      if (inst !== 32'h00000013) $display("FAIL stall_inst[%0d]: got %h exp 00000013", i, inst); else n_pass++; n_total++;
      if (ipc !== 32'h0) $display("FAIL stall_pc[%0d]: got %h exp 0", i, ipc); else n_pass++; n_total++;
      if (req !== 1'b0) $display("FAIL stall_req[%0d]: got %h exp 0", i, req); else n_pass++; n_total++;
      tick();
      if (i == 2) rob_stall = 0;
      #1;
    end
    if (req !== 1'b1) $display("FAIL stall_release_req: got %h exp 1", req); else n_pass++; n_total++;
    if (ivld !== 1'b1) $display("FAIL stall_release_valid: got %h exp 1", ivld); else n_pass++; n_total++;
    tick(); dvalid = 1; dat = BLK0;
    tick(); dvalid = 0; #1;
    if (ipc !== 32'h4) $display("FAIL stall_next_pc: got %h exp 4", ipc); else n_pass++; n_total++;
    if (inst !== 32'h00100093) $display("FAIL stall_next_inst: got %h exp 00100093", inst); else n_pass++; n_total++;
  endtask

  task automatic test_redirect_drop();
    do_reset();
    tick();
    tick(); cbr = 1; cbpc = 32'h100; #1;
    if (req !== 1'b0) $display("FAIL drop_redir_req: got %h exp 0", req); else n_pass++; n_total++;
    tick(); cbr = 0; #1;
    if (ivld !== 1'b0) $display("FAIL drop_valid0: got %h exp 0", ivld); else n_pass++; n_total++;
    if (req !== 1'b0) $display("FAIL drop_req0: got %h exp 0", req); else n_pass++; n_total++;
    tick(); dvalid = 1; dat = BLK0; #1;
    if (req !== 1'b0) $display("FAIL drop_stale_req: got %h exp 0", req); else n_pass++; n_total++;
    tick(); dvalid = 0; #1;
    if (ivld !== 1'b0) $display("FAIL drop_after_valid: got %h exp 0", ivld); else n_pass++; n_total++;
    if (req !== 1'b1) $display("FAIL drop_after_req: got %h exp 1", req); else n_pass++; n_total++;
    if (addr !== 32'h100) $display("FAIL drop_after_addr: got %h exp 100", addr); else n_pass++; n_total++;
  endtask

  task automatic test_priority();
    do_reset();
    tick(); cbr = 1; cbpc = 32'h200; rtr = 1; rtpc = 32'h300;
    tick(); clr_in(); #1;
    if (addr !== 32'h200) $display("FAIL prio_pc: got %h exp 200", addr); else n_pass++; n_total++;
    tick(); dvalid = 1; dat = BLK0;
    tick(); dvalid = 0; #1;
    if (req !== 1'b1) $display("FAIL prio_req: got %h exp 1", req); else n_pass++; n_total++;
    if (addr !== 32'h200) $display("FAIL prio_addr: got %h exp 200", addr); else n_pass++; n_total++;
  endtask

  task automatic test_out_redirect();
    do_reset();
    tick(); dvalid = 1; dat = BLK0;
    tick(); dvalid = 0; rtr = 1; rtpc = 32'h303; #1;
    if (req !== 1'b0) $display("FAIL outred_req: got %h exp 0", req); else n_pass++; n_total++;
    tick(); clr_in(); #1;
    if (ivld !== 1'b0) $display("FAIL outred_valid: got %h exp 0", ivld); else n_pass++; n_total++;
    if (req !== 1'b1) $display("FAIL outred_next_req: got %h exp 1", req); else n_pass++; n_total++;
    if (addr !== 32'h300) $display("FAIL outred_next_addr: got %h exp 300", addr); else n_pass++; n_total++;
    tick(); dvalid = 1; dat = 64'hAAAA_BBBB_CCCC_DDDD;
    tick(); dvalid = 0; #1;
    if (ipc !== 32'h300) $display("FAIL outred_if_pc: got %h exp 300", ipc); else n_pass++; n_total++;
    if (inst !== 32'hCCCC_DDDD) $display("FAIL outred_if_inst: got %h exp ccccdddd", inst); else n_pass++; n_total++;
  endtask

  task automatic test_pred();
    logic [31:0] exp_npc, exp_addr;
`ifdef FETCH_PRED_EN
    exp_npc = 32'h40; exp_addr = 32'h40;
`else
    exp_npc = 32'h14; exp_addr = 32'h10;
`endif
    do_reset();
    tick(); cbr = 1; cbpc = 32'h10; dvalid = 1; dat = BLK0;
    tick(); clr_in(); #1;
    if (req !== 1'b1) $display("FAIL pred_req10: got %h exp 1", req); else n_pass++; n_total++;
    if (addr !== 32'h10) $display("FAIL pred_addr10: got %h exp 10", addr); else n_pass++; n_total++;
    tick(); dvalid = 1; dat = 64'h1111_1111_2222_2222; bpr = 1; bppc = 32'h40;
    tick(); clr_in(); #1;
    if (ipc !== 32'h10) $display("FAIL pred_if_pc: got %h exp 10", ipc); else n_pass++; n_total++;
    if (inst !== 32'h2222_2222) $display("FAIL pred_if_inst: got %h exp 22222222", inst); else n_pass++; n_total++;
    if (inpc !== exp_npc) $display("FAIL pred_if_npc: got %h exp %h", inpc, exp_npc); else n_pass++; n_total++;
    if (addr !== exp_addr) $display("FAIL pred_next_addr: got %h exp %h", addr, exp_addr); else n_pass++; n_total++;
  endtask

  task automatic test_wrap();
    do_reset();
    if (req2 !== 1'b1) $display("FAIL wrap_req: got %h exp 1", req2); else n_pass++; n_total++;
    if (addr2 !== 32'hFFFF_FFF8) $display("FAIL wrap_addr: got %h exp fffffff8", addr2); else n_pass++; n_total++;
    tick(); dvalid = 1; dat = 64'hDEAD_BEEF_0000_0000;
    tick(); dvalid = 0; #1;
    if (ivld2 !== 1'b1) $display("FAIL wrap_valid: got %h exp 1", ivld2); else n_pass++; n_total++;
    if (inst2 !== 32'hDEAD_BEEF) $display("FAIL wrap_inst: got %h exp deadbeef", inst2); else n_pass++; n_total++;
    if (ipc2 !== 32'hFFFF_FFFC) $display("FAIL wrap_pc: got %h exp fffffffc", ipc2); else n_pass++; n_total++;
    if (inpc2 !== 32'h0) $display("FAIL wrap_npc: got %h exp 0", inpc2); else n_pass++; n_total++;
    if (addr2 !== 32'h0) $display("FAIL wrap_next_addr: got %h exp 0", addr2); else n_pass++; n_total++;
    if (req2 !== 1'b1) $display("FAIL wrap_next_req: got %h exp 1", req2); else n_pass++; n_total++;
  endtask

  initial begin
    clr_in(); reset = 1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_drop();
    test_priority();
    test_out_redirect();
    test_pred();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
